btb: RTL and testbench

- Branch Target Buffer in the IF stage of the 5-stage RV32 pipeline. It is the direct upstream feeder of the BHT direction predictor.
- Each cycle it looks up the fetch PC combinationally and returns a hit flag plus a predicted target. The BHT and NPC logic then decide whether to redirect fetch.
- Entries are allocated and refreshed from EX-stage branch resolution. Saturating hit/lookup counters support prediction statistics.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/sat_counter.sv | 18 +
 rtl/btb.sv | 73 +++++++
 tb/tb_btb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: branch-type encodings and PC index/tag helpers shared by the BTB and BHT.
package bp_pkg;
    localparam int BP_IDX_W = 4;
    localparam int BP_TAG_W = 30 - BP_IDX_W;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BGE      = 3'd4,
        BLTU     = 3'd5,
        BGEU     = 3'd6
    } br_type_e;

    function automatic logic [31:0] pc_idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) r_cnt <= '0;
        else if (inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/btb.sv
// btb: direct-mapped branch target buffer with combinational lookup and saturating hit/lookup counters.
module btb
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = 30 - IDX_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PCF,
    input  logic             StallF,
    input  logic [31:0]      PCE,
    input  logic [31:0]      BrNPC,
    input  logic             BranchE,
    input  logic [2:0]       BranchTypeE,
    output logic             BTBhit,
    output logic [31:0]      PredTarget,
    output logic [CNT_W-1:0] LookupCnt,
    output logic [CNT_W-1:0] HitCnt
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [29:0]        r_target [ENTRIES];

    logic [IDX_W-1:0] w_idx, w_uidx;
    logic [TAG_W-1:0] w_tag, w_utag;
    logic             w_we, w_lookup, w_hit, w_clr, w_unused;

    assign w_idx  = IDX_W'(pc_idx(PCF, IDX_W));
    assign w_tag  = TAG_W'(pc_tag(PCF, IDX_W));
    assign w_uidx = IDX_W'(pc_idx(PCE, IDX_W));
    assign w_utag = TAG_W'(pc_tag(PCE, IDX_W));
    assign w_unused = ^BrNPC[1:0];

    // Only taken conditional branches allocate; jumps and not-taken outcomes leave the entry alone.
    assign w_we = rst && BranchE && (BranchTypeE != NOBRANCH);

    assign BTBhit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign PredTarget = BTBhit ? {r_target[w_idx], 2'b00} : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) r_valid <= '0;
        else if (w_we) r_valid[w_uidx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= BrNPC[31:2];
        end
    end

    assign w_clr    = !rst;
    assign w_lookup = !StallF;
    assign w_hit    = !StallF && BTBhit;

    sat_counter #(.W(CNT_W)) u_lookup_cnt (
        .clk (clk),
        .inc (w_lookup),
        .clr (w_clr),
        .cnt (LookupCnt)
    );

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .inc (w_hit),
        .clr (w_clr),
        .cnt (HitCnt)
    );
endmodule

// File: tb/tb_btb.sv
// tb_btb: directed self-checking bench for btb, built with 4-bit counters to reach saturation quickly.
module tb_btb;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCE, BrNPC;
    logic        StallF, BranchE;
    logic [2:0]  BranchTypeE;
    logic        BTBhit;
    logic [31:0] PredTarget;
    logic [3:0]  LookupCnt, HitCnt;
    int          errors = 0;
    int          checks = 0;

    btb #(.IDX_W(4), .TAG_W(26), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .StallF      (StallF),
        .PCE         (PCE),
        .BrNPC       (BrNPC),
        .BranchE     (BranchE),
        .BranchTypeE (BranchTypeE),
        .BTBhit      (BTBhit),
        .PredTarget  (PredTarget),
        .LookupCnt   (LookupCnt),
        .HitCnt      (HitCnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        BranchE = 1'b0;
        BranchTypeE = 3'd0;
        StallF = 1'b1;
        #1;
    endtask

    task automatic write(input logic [31:0] pc, input logic [31:0] tgt, input logic taken, input logic [2:0] typ);
        PCE = pc;
        BrNPC = tgt;
        BranchE = taken;
        BranchTypeE = typ;
        StallF = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        PCF = 32'h10;
        PCE = 32'h0;
        BrNPC = 32'h0;
        BranchE = 1'b0;
        BranchTypeE = 3'd0;
        StallF = 1'b0;
        cyc();
        cyc();
        checks++; if (LookupCnt !== 4'd0) begin errors++; $display("FAIL reset_lookup got=%0d exp=0", LookupCnt); end
        checks++; if (HitCnt !== 4'd0) begin errors++; $display("FAIL reset_hitcnt got=%0d exp=0", HitCnt); end
        rst = 1'b1;
        #1;
        checks++; if (BTBhit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", BTBhit); end
        checks++; if (PredTarget !== 32'h0) begin errors++; $display("FAIL reset_target got=%h exp=00000000", PredTarget); end
        cyc();
        checks++; if (LookupCnt !== 4'd1) begin errors++; $display("FAIL reset_first_lookup got=%0d exp=1", LookupCnt); end
        checks++; if (HitCnt !== 4'd0) begin errors++; $display("FAIL reset_first_hitcnt got=%0d exp=0", HitCnt); end
        idle();
    endtask

    task automatic test_alloc_hit();
        write(32'h10, 32'h40, 1'b1, 3'd1);
        PCF = 32'h10;
        StallF = 1'b0;
        #1;
        checks++; if (BTBhit !== 1'b1) begin errors++; $display("FAIL alloc_hit got=%b exp=1", BTBhit); end
        checks++; if (PredTarget !== 32'h40) begin errors++; $display("FAIL alloc_target got=%h exp=00000040", PredTarget); end
        cyc();
        checks++; if (HitCnt !== 4'd1) begin errors++; $display("FAIL alloc_hitcnt got=%0d exp=1", HitCnt); end
        checks++; if (LookupCnt !== 4'd2) begin errors++; $display("FAIL alloc_lookup got=%0d exp=2", LookupCnt); end
        idle();
    endtask

    task automatic test_retention();
        write(32'h10, 32'h80, 1'b0, 3'd1);
        write(32'h10, 32'h80, 1'b1, 3'd0);
        write(32'h30, 32'h90, 1'b1, 3'd0);
        PCF = 32'h10;
        #1;
        checks++; if (BTBhit !== 1'b1) begin errors++; $display("FAIL retain_hit got=%b exp=1", BTBhit); end
        checks++; if (PredTarget !== 32'h40) begin errors++; $display("FAIL retain_target got=%h exp=00000040", PredTarget); end
        PCF = 32'h30;
        #1;
        checks++; if (BTBhit !== 1'b0) begin errors++; $display("FAIL jump_no_alloc got=%b exp=0", BTBhit); end
    endtask

    task automatic test_alias();
        write(32'h50, 32'h100, 1'b1, 3'd2);
        PCF = 32'h10;
        #1;
        checks++; if (BTBhit !== 1'b0) begin errors++; $display("FAIL alias_old_hit got=%b exp=0", BTBhit); end
        checks++; if (PredTarget !== 32'h0) begin errors++; $display("FAIL alias_old_target got=%h exp=00000000", PredTarget); end
        PCF = 32'h50;
        #1;
        checks++; if (BTBhit !== 1'b1) begin errors++; $display("FAIL alias_new_hit got=%b exp=1", BTBhit); end
        checks++; if (PredTarget !== 32'h100) begin errors++; $display("FAIL alias_new_target got=%h exp=00000100", PredTarget); end
        PCF = 32'h53;
        #1;
        checks++; if (PredTarget !== 32'h100) begin errors++; $display("FAIL low_bits_ignored got=%h exp=00000100", PredTarget); end
    endtask

    task automatic test_same_cycle();
        PCF = 32'h20;
        PCE = 32'h20;
        BrNPC = 32'h203;
        BranchE = 1'b1;
        BranchTypeE = 3'd3;
        #1;
        checks++; if (BTBhit !== 1'b0) begin errors++; $display("FAIL rw_same_hit got=%b exp=0", BTBhit); end
        checks++; if (PredTarget !== 32'h0) begin errors++; $display("FAIL rw_same_target got=%h exp=00000000", PredTarget); end
        cyc();
        idle();
        checks++; if (BTBhit !== 1'b1) begin errors++; $display("FAIL rw_next_hit got=%b exp=1", BTBhit); end
        checks++; if (PredTarget !== 32'h200) begin errors++; $display("FAIL rw_next_target got=%h exp=00000200", PredTarget); end
    endtask

    task automatic test_stall();
        PCF = 32'h20;
        StallF = 1'b1;
        PCE = 32'h24;
        BrNPC = 32'h300;
        BranchE = 1'b1;
        BranchTypeE = 3'd4;
        cyc();
        BranchE = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (LookupCnt !== 4'd2) begin errors++; $display("FAIL stall_lookup got=%0d exp=2", LookupCnt); end
        checks++; if (HitCnt !== 4'd1) begin errors++; $display("FAIL stall_hitcnt got=%0d exp=1", HitCnt); end
        idle();
        PCF = 32'h24;
        #1;
        checks++; if (PredTarget !== 32'h300) begin errors++; $display("FAIL stall_update got=%h exp=00000300", PredTarget); end
    endtask

    task automatic test_saturation();
        PCF = 32'h20;
        StallF = 1'b0;
        for (int i = 0; i < 13; i++) cyc();
        checks++; if (LookupCnt !== 4'd15) begin errors++; $display("FAIL sat_lookup_13 got=%0d exp=15", LookupCnt); end
        checks++; if (HitCnt !== 4'd14) begin errors++; $display("FAIL sat_hitcnt_13 got=%0d exp=14", HitCnt); end
        for (int i = 0; i < 7; i++) cyc();
        checks++; if (LookupCnt !== 4'd15) begin errors++; $display("FAIL sat_lookup_held got=%0d exp=15", LookupCnt); end
        checks++; if (HitCnt !== 4'd15) begin errors++; $display("FAIL sat_hitcnt_held got=%0d exp=15", HitCnt); end
        idle();
    endtask

    task automatic test_mid_reset();
        rst = 1'b0;
        StallF = 1'b0;
        PCF = 32'h20;
        PCE = 32'h30;
        BrNPC = 32'h400;
        BranchE = 1'b1;
        BranchTypeE = 3'd1;
        cyc();
        checks++; if (LookupCnt !== 4'd0) begin errors++; $display("FAIL midrst_lookup got=%0d exp=0", LookupCnt); end
        checks++; if (HitCnt !== 4'd0) begin errors++; $display("FAIL midrst_hitcnt got=%0d exp=0", HitCnt); end
        checks++; if (BTBhit !== 1'b0) begin errors++; $display("FAIL midrst_entry_kept got=%b exp=0", BTBhit); end
        rst = 1'b1;
        BranchE = 1'b0;
        BranchTypeE = 3'd0;
        PCF = 32'h30;
        #1;
        checks++; if (BTBhit !== 1'b0) begin errors++; $display("FAIL midrst_update_won got=%b exp=0", BTBhit); end
        PCF = 32'h24;
        #1;
        checks++; if (BTBhit !== 1'b0) begin errors++; $display("FAIL midrst_first_lookup got=%b exp=0", BTBhit); end
        cyc();
        checks++; if (LookupCnt !== 4'd1) begin errors++; $display("FAIL midrst_relook got=%0d exp=1", LookupCnt); end
        checks++; if (HitCnt !== 4'd0) begin errors++; $display("FAIL midrst_rehit got=%0d exp=0", HitCnt); end
        idle();
    endtask

    task automatic test_back_to_back();
        StallF = 1'b1;
        BranchE = 1'b1;
        BranchTypeE = 3'd5;
        PCE = 32'h40; BrNPC = 32'h500; cyc();
        PCE = 32'h44; BrNPC = 32'h504; cyc();
        PCE = 32'h48; BrNPC = 32'h508; cyc();
        idle();
        PCF = 32'h40; #1;
        checks++; if (PredTarget !== 32'h500) begin errors++; $display("FAIL b2b_0 got=%h exp=00000500", PredTarget); end
        PCF = 32'h44; #1;
        checks++; if (PredTarget !== 32'h504) begin errors++; $display("FAIL b2b_1 got=%h exp=00000504", PredTarget); end
        PCF = 32'h48; #1;
        checks++; if (PredTarget !== 32'h508) begin errors++; $display("FAIL b2b_2 got=%h exp=00000508", PredTarget); end
        PCF = 32'h4C; #1;
        checks++; if (BTBhit !== 1'b0) begin errors++; $display("FAIL b2b_neighbor got=%b exp=0", BTBhit); end
    endtask

    initial begin
        test_reset();
        test_alloc_hit();
        test_retention();
        test_alias();
        test_same_cycle();
        test_stall();
        test_saturation();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
